bubbledrive8_pwrmon: RTL and testbench
======================================

BUBBLEDRIVE8_PWRMON -- requirements
Module: BubbleDrive8_pwrmon

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 48000, sets the slow filter length in MCLK cycles: 1 ms at 48 MHz, used for every settle and release.
REQ-002 Parameter FAIL_CYCLES, default 48, sets the fast filter length for MRST 0->1 (board power loss).
REQ-003 Parameter CNT_W, default 16, is the filter counter width; it SHALL hold DEBOUNCE_CYCLES.
REQ-004 MCLK  in  1  48 MHz system clock; the only clock.
REQ-005 nRESET  in  1  asynchronous, active-low reset.
REQ-006 MRST  in  1  raw PCB power status; 0 = board power good.
REQ-007 PWRSTAT  in  1  raw power-mux status; 0 = motherboard, 1 = USB.
REQ-008 MODE  out  2  filtered {PWRSTAT, MRST} pair, consumed by the startup controller.
REQ-009 VALID  out  1  high once the initial settle is complete.
REQ-010 nCHANGE  out  1  active-low, one-cycle pulse when MODE changes while in RUN.
REQ-011 CHANGECNT  out  8  saturating count of nCHANGE pulses, for diagnostics.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchroniser; synchroniser flops reset to 1.
REQ-013 Top FSM states: INIT and RUN; reset enters INIT.
REQ-014 INIT: a shared counter increments each cycle both synchronised inputs equal their previous-cycle values, and clears to 0 on any difference.
REQ-015 INIT exit: on the cycle the counter reaches DEBOUNCE_CYCLES-1, MODE loads the synchronised pair, VALID rises, the state becomes RUN, and no nCHANGE pulse is generated.
REQ-016 RUN: each channel counter increments while its synchronised value differs from its MODE bit, and clears to 0 on the first cycle they match.
REQ-017 Thresholds: MRST 0->1 uses FAIL_CYCLES; MRST 1->0 and both PWRSTAT directions use DEBOUNCE_CYCLES.
REQ-018 A MODE bit SHALL toggle on the cycle its counter reaches threshold-1, so pad-to-MODE latency is threshold+2 cycles; the counter then clears.
REQ-019 A glitch shorter than the threshold SHALL leave MODE unchanged, and the counter restarts from 0 on the next difference.
REQ-020 nCHANGE SHALL be low for exactly the one cycle after any MODE update in RUN.
REQ-021 Simultaneous update of both bits yields one nCHANGE pulse and one CHANGECNT increment.
REQ-022 CHANGECNT increments with each nCHANGE pulse and holds at 255.
REQ-023 RUN never returns to INIT except via nRESET.
REQ-024 Counters SHALL not wrap; the threshold compare occurs before overflow, guaranteed by REQ-003.

Reset
REQ-025 nRESET low asynchronously forces the following: MODE=2'b11 (standby, safe), VALID=0, nCHANGE=1, CHANGECNT=0, all counters 0, state INIT.
REQ-026 nRESET asserted mid-filter discards all partial counts, and the release restarts the INIT settle from 0.

Structure
REQ-027 Shared package holds the MODE encodings EMU=2'b00, ERR_BOARD=2'b01, ERR_USB=2'b10 and STANDBY=2'b11, plus the default DEBOUNCE_CYCLES and FAIL_CYCLES.
REQ-028 One sub-module, BubbleDrive8_pwrmon_filter, is instantiated twice, once per channel. It contains the synchroniser, counter and the rise/fall threshold parameters.
REQ-029 The top level holds the INIT/RUN FSM, the change detect and CHANGECNT.

Verification (bench uses DEBOUNCE_CYCLES=16, FAIL_CYCLES=4)
REQ-030 Reset release with MRST=0, PWRSTAT=0 held -> VALID rises and MODE=00 at cycle 18 after release, with nCHANGE held 1.
REQ-031 In RUN with MODE=00, MRST pulses high for 3 cycles -> MODE stays 00 and no nCHANGE pulse; held high -> MODE=01 six cycles after the edge, one nCHANGE pulse, CHANGECNT=1.
REQ-032 In RUN with MODE=01, MRST returns to 0 -> MODE=00 exactly 18 cycles later, and a 15-cycle low glitch is rejected.
REQ-033 In RUN, MRST and PWRSTAT fall together from 11 -> MODE=00 after 18 cycles, one nCHANGE pulse, CHANGECNT+1.
REQ-034 PWRSTAT toggled every 20 cycles for 300 toggles -> CHANGECNT saturates at 255, and nCHANGE keeps pulsing.
REQ-035 nRESET asserted at count 10 of a PWRSTAT settle -> outputs take reset values immediately, and after release VALID follows the REQ-030 timing.

Source files
------------

// File: rtl/bubbledrive8_pwrmon_pkg.sv
// Shared definitions for the BubbleDrive8 power monitor: MODE encodings,
// default filter lengths and the top-level state type.
package bubbledrive8_pwrmon_pkg;

  // MODE is the filtered {PWRSTAT, MRST} pair.
  localparam logic [1:0] MODE_EMU       = 2'b00;  // motherboard power, board good
  localparam logic [1:0] MODE_ERR_BOARD = 2'b01;  // motherboard power, board lost
  localparam logic [1:0] MODE_ERR_USB   = 2'b10;  // USB power, board good
  localparam logic [1:0] MODE_STANDBY   = 2'b11;  // safe state held through reset

  // 1 ms settle at 48 MHz, and a 1 us fast path for board power loss.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 48000;
  localparam int DEFAULT_FAIL_CYCLES     = 48;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/bubbledrive8_pwrmon_filter.sv
// One power-status channel: 2-flop synchroniser, a previous-value flop used
// by the shared INIT settle, and the RUN-mode change filter with separate
// thresholds for 0->1 and 1->0 moves of the filtered bit.
module bubbledrive8_pwrmon_filter #(
  parameter int RISE_CYCLES = 48000,  // filtered bit 0 -> 1
  parameter int FALL_CYCLES = 48000,  // filtered bit 1 -> 0
  parameter int CNT_W       = 16
) (
  input  logic MCLK,
  input  logic nRESET,
  input  logic raw,       // asynchronous pad input
  input  logic run,       // top FSM is in RUN
  input  logic mode_bit,  // current filtered value owned by the top
  output logic sync,      // synchronised input
  output logic stable,    // synchronised input equals its previous-cycle value
  output logic toggle     // filtered bit must flip this cycle
);

  logic             sync_meta;
  logic             sync_q;
  logic             sync_prev;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] thr_m1;
  logic             differ;

  // Synchroniser plus one history flop; all reset high to match standby.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      sync_meta <= 1'b1;
      sync_q    <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
      sync_prev <= sync_q;
    end
  end

  // Run-length of disagreement between the input and the filtered bit.
  // NOTE: every output of this block gets a value before any branch, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    thr_m1 = mode_bit ? CNT_W'(FALL_CYCLES - 1) : CNT_W'(RISE_CYCLES - 1);
    differ = run && (sync_q != mode_bit);
    toggle = differ && (cnt_q == thr_m1);
    cnt_d  = '0;
    if (differ && !toggle) cnt_d = cnt_q + CNT_W'(1);
  end

  // Filter counter register.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign sync   = sync_q;
  assign stable = (sync_q == sync_prev);

endmodule

// File: rtl/bubbledrive8_pwrmon.sv
// BubbleDrive8 power monitor. Filters the raw board-power (MRST) and
// power-mux (PWRSTAT) signals into MODE for the startup controller. After
// reset both inputs must sit still for DEBOUNCE_CYCLES before MODE is first
// loaded; afterwards each bit moves only once its input has disagreed for
// the channel threshold, and every move is flagged on nCHANGE.
module bubbledrive8_pwrmon
  import bubbledrive8_pwrmon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int FAIL_CYCLES     = DEFAULT_FAIL_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic       MCLK,
  input  logic       nRESET,
  input  logic       MRST,
  input  logic       PWRSTAT,
  output logic [1:0] MODE,
  output logic       VALID,
  output logic       nCHANGE,
  output logic [7:0] CHANGECNT
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic [1:0]       mode_d;
  logic             valid_d;
  logic             nchange_d;
  logic [7:0]       changecnt_d;
  logic             run;
  logic             mrst_sync, mrst_stable, mrst_toggle;
  logic             pwr_sync, pwr_stable, pwr_toggle;

  assign run = (state_q == ST_RUN);

  // Board power: loss (0->1) must be seen quickly, recovery is debounced.
  bubbledrive8_pwrmon_filter #(
    .RISE_CYCLES(FAIL_CYCLES),
    .FALL_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W      (CNT_W)
  ) u_mrst (
    .MCLK    (MCLK),
    .nRESET  (nRESET),
    .raw     (MRST),
    .run     (run),
    .mode_bit(MODE[0]),
    .sync    (mrst_sync),
    .stable  (mrst_stable),
    .toggle  (mrst_toggle)
  );

  // Power mux: both directions debounced.
  bubbledrive8_pwrmon_filter #(
    .RISE_CYCLES(DEBOUNCE_CYCLES),
    .FALL_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W      (CNT_W)
  ) u_pwr (
    .MCLK    (MCLK),
    .nRESET  (nRESET),
    .raw     (PWRSTAT),
    .run     (run),
    .mode_bit(MODE[1]),
    .sync    (pwr_sync),
    .stable  (pwr_stable),
    .toggle  (pwr_toggle)
  );

  // Next state, MODE update, change pulse and saturating change counter.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    mode_d      = MODE;
    valid_d     = VALID;
    nchange_d   = 1'b1;
    changecnt_d = CHANGECNT;
    case (state_q)
      ST_INIT: begin
        if (mrst_stable && pwr_stable) begin
          // Leave INIT on the cycle the settle count arrives at
          // DEBOUNCE_CYCLES-1; the initial load is not a change.
          if (init_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 2)) begin
            mode_d     = {pwr_sync, mrst_sync};
            valid_d    = 1'b1;
            state_d    = ST_RUN;
            init_cnt_d = '0;
          end else begin
            init_cnt_d = init_cnt_q + CNT_W'(1);
          end
        end else begin
          init_cnt_d = '0;
        end
      end
      ST_RUN: begin
        // Both channels may flip together; that still counts as one change.
        if (mrst_toggle || pwr_toggle) begin
          mode_d    = MODE ^ {pwr_toggle, mrst_toggle};
          nchange_d = 1'b0;
          if (CHANGECNT != 8'hFF) changecnt_d = CHANGECNT + 8'd1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Registered state and outputs; reset parks MODE in standby.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      MODE       <= MODE_STANDBY;
      VALID      <= 1'b0;
      nCHANGE    <= 1'b1;
      CHANGECNT  <= 8'd0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      MODE       <= mode_d;
      VALID      <= valid_d;
      nCHANGE    <= nchange_d;
      CHANGECNT  <= changecnt_d;
    end
  end

endmodule

// File: tb/tb_bubbledrive8_pwrmon.sv
// Directed bench for bubbledrive8_pwrmon with DEBOUNCE_CYCLES=16 and
// FAIL_CYCLES=4: settle 18 cycles, fast loss 6 cycles, debounced moves 18.
module tb_bubbledrive8_pwrmon;

  logic       MCLK = 1'b0;
  logic       nRESET;
  logic       MRST;
  logic       PWRSTAT;
  logic [1:0] MODE;
  logic       VALID;
  logic       nCHANGE;
  logic [7:0] CHANGECNT;

  int n_total = 0;
  int n_bad   = 0;
  int n_pulse = 0;
  int p0;

  bubbledrive8_pwrmon #(
    .DEBOUNCE_CYCLES(16),
    .FAIL_CYCLES    (4),
    .CNT_W          (16)
  ) dut (
    .MCLK     (MCLK),
    .nRESET   (nRESET),
    .MRST     (MRST),
    .PWRSTAT  (PWRSTAT),
    .MODE     (MODE),
    .VALID    (VALID),
    .nCHANGE  (nCHANGE),
    .CHANGECNT(CHANGECNT)
  );

  always #5 MCLK = ~MCLK;

  // Count cycles with nCHANGE low, sampled away from the active edge.
  always @(negedge MCLK) begin
    if (nRESET === 1'b1 && nCHANGE === 1'b0) n_pulse++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge MCLK);
    #1;
  endtask

  // Release reset just after an edge, then expect the 18-cycle settle.
  task automatic settle_check(input string tag);
    p0 = n_pulse;
    nRESET = 1'b1;
    step(17);
    check({tag, "_valid17"}, 32'(VALID), 32'd0);
    check({tag, "_mode17"}, 32'(MODE), 32'h3);
    step(1);
    check({tag, "_valid18"}, 32'(VALID), 32'd1);
    check({tag, "_mode18"}, 32'(MODE), 32'h0);
    check({tag, "_nchg"}, 32'(nCHANGE), 32'd1);
    step(5);
    check({tag, "_nopulse"}, 32'(n_pulse - p0), 32'd0);
    check({tag, "_cnt"}, 32'(CHANGECNT), 32'd0);
  endtask

  initial begin
    nRESET  = 1'b0;
    MRST    = 1'b0;
    PWRSTAT = 1'b0;
    step(3);
    check("rst_mode", 32'(MODE), 32'h3);
    check("rst_valid", 32'(VALID), 32'd0);
    check("rst_nchg", 32'(nCHANGE), 32'd1);
    check("rst_cnt", 32'(CHANGECNT), 32'd0);

    settle_check("init");

    // Short board-power loss glitch is rejected.
    p0 = n_pulse;
    MRST = 1'b1;
    step(3);
    MRST = 1'b0;
    step(20);
    check("glitch3_mode", 32'(MODE), 32'h0);
    check("glitch3_pulse", 32'(n_pulse - p0), 32'd0);

    // Sustained loss: MODE=01 six edges after the pad changes.
    p0 = n_pulse;
    MRST = 1'b1;
    step(5);
    check("loss_mode5", 32'(MODE), 32'h0);
    step(1);
    check("loss_mode6", 32'(MODE), 32'h1);
    check("loss_nchg_lo", 32'(nCHANGE), 32'd0);
    step(1);
    check("loss_nchg_hi", 32'(nCHANGE), 32'd1);
    check("loss_cnt", 32'(CHANGECNT), 32'd1);
    check("loss_pulse", 32'(n_pulse - p0), 32'd1);

    // 15-cycle recovery glitch is rejected, then a real recovery takes 18.
    MRST = 1'b0;
    step(15);
    MRST = 1'b1;
    step(25);
    check("glitch15_mode", 32'(MODE), 32'h1);
    check("glitch15_cnt", 32'(CHANGECNT), 32'd1);
    MRST = 1'b0;
    step(17);
    check("recov_mode17", 32'(MODE), 32'h1);
    step(1);
    check("recov_mode18", 32'(MODE), 32'h0);
    step(1);
    check("recov_cnt", 32'(CHANGECNT), 32'd2);

    // Go to 11 (two separate changes), then fall together from 11.
    MRST    = 1'b1;
    PWRSTAT = 1'b1;
    step(30);
    check("both_hi_mode", 32'(MODE), 32'h3);
    check("both_hi_cnt", 32'(CHANGECNT), 32'd4);
    p0 = n_pulse;
    MRST    = 1'b0;
    PWRSTAT = 1'b0;
    step(17);
    check("both_lo_mode17", 32'(MODE), 32'h3);
    step(1);
    check("both_lo_mode18", 32'(MODE), 32'h0);
    step(5);
    check("both_lo_pulse", 32'(n_pulse - p0), 32'd1);
    check("both_lo_cnt", 32'(CHANGECNT), 32'd5);

    // 300 PWRSTAT toggles: counter saturates, pulses keep coming.
    p0 = n_pulse;
    for (int i = 0; i < 300; i++) begin
      PWRSTAT = ~PWRSTAT;
      step(20);
    end
    check("sat_cnt", 32'(CHANGECNT), 32'd255);
    check("sat_pulse", 32'(n_pulse - p0), 32'd300);
    check("sat_mode", 32'(MODE), 32'h0);

    // Reset mid-settle at filter count 10, then a clean 18-cycle settle.
    PWRSTAT = 1'b1;
    step(12);
    check("mid_mode_before", 32'(MODE), 32'h0);
    nRESET = 1'b0;
    #1;
    check("mid_rst_mode", 32'(MODE), 32'h3);
    check("mid_rst_valid", 32'(VALID), 32'd0);
    check("mid_rst_nchg", 32'(nCHANGE), 32'd1);
    check("mid_rst_cnt", 32'(CHANGECNT), 32'd0);
    PWRSTAT = 1'b0;
    step(3);
    settle_check("reinit");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule
